act_cfg_loader: RTL
===================

# act_cfg_loader

Configuration loader that writes the programming bits of a chain of Actel-style logic modules (C1/C2/S1/S2 cells with their mux selects and data taps). It accepts configuration words from a parallel producer over a valid/ready handshake and serialises them, MSB first, onto a scan chain. When the last bit is shifted it pulses a latch strobe so the cells capture the chain. It is the writer end of the cell configuration interface; each logic module's configuration register is the reader end.

## Interface

- WORD_W, 8, width of one configuration word; must be ≥ 2.
- CHAIN_LEN, 32, total chain length in bits; must be an integer multiple of WORD_W. NWORDS = CHAIN_LEN / WORD_W.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high; forces IDLE and all outputs to 0.
- start  in  1  request a load session; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in every state.
- word_in  in  WORD_W  configuration word from the producer.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  the loader accepts a word this cycle.
- cfg_sdo  out  1  serial data to the chain head.
- cfg_shift  out  1  chain shift enable; the chain shifts cfg_sdo on every clk edge where this is high.
- cfg_latch  out  1  one-cycle strobe; the cells copy the chain into their configuration registers.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after a completed session.

## Operation

- FSM states: IDLE, WAIT_WORD, SHIFT, LATCH, DONE.
- Registers:
  - sreg[WORD_W-1:0], the shift register.
  - bit_cnt, width clog2(WORD_W).
  - word_cnt, width clog2(NWORDS) with a minimum of 1 bit.
- IDLE: all outputs 0.
  - If start=1 and abort=0: go to WAIT_WORD and clear word_cnt.
- WAIT_WORD: word_ready=1.
  - On word_valid=1: load sreg←word_in, clear bit_cnt, go to SHIFT.
  - If word_valid=0: stay in WAIT_WORD indefinitely.
- SHIFT: cfg_shift=1, cfg_sdo=sreg[WORD_W-1]. Each cycle sreg shifts left by one (0 enters the LSB) and bit_cnt increments.
  - When bit_cnt=WORD_W-1 and word_cnt=NWORDS-1: go to LATCH.
  - When bit_cnt=WORD_W-1 otherwise: increment word_cnt and go to WAIT_WORD.
- LATCH: cfg_latch=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Bit order:
  - Words are sent in arrival order, MSB first within each word.
  - The first bit sent ends at the chain tail (position CHAIN_LEN-1).
- All outputs are Moore decodes of the state register plus sreg[WORD_W-1]. There is no combinational path from any input to any output.
- Boundary conditions:
  - abort in any non-IDLE state: next state IDLE, counters cleared. cfg_latch and done are never asserted for an aborted session. Partial chain contents are left as is.
  - abort and start in the same IDLE cycle: abort wins and the FSM stays in IDLE.
  - start outside IDLE is ignored. word_valid outside WAIT_WORD is ignored and no word is consumed.
  - rst asserted mid-session: IDLE immediately, without waiting for a clock edge. All outputs are 0 and sreg/counters are 0.
  - NWORDS=1: word_cnt is never incremented.

## Timing

- Reset values: word_ready, cfg_sdo, cfg_shift, cfg_latch, busy and done are all 0.
- start sampled at edge e0: busy and word_ready are high from just after e0.
- Handshake at edge t: cfg_shift is high for the WORD_W cycles that follow. The next word_ready rises after edge t+WORD_W.
- Throughput: WORD_W+1 cycles per word with word_valid held high. No back-to-back acceptance.
- Session length from e0 back to IDLE: NWORDS·(WORD_W+1)+2 cycles. With the defaults this is 38 cycles.
- cfg_latch is high in the cycle immediately after the last shift cycle. done is high in the cycle after cfg_latch.
- abort sampled at edge t: all outputs are 0 from just after edge t.

## Test plan

- **Reset:** assert rst asynchronously during the 5th bit of word 2 → all outputs 0 before the next edge. After release the loader is in IDLE and a new start loads correctly.
- **Full load, defaults:** words 0xA5, 0x3C, 0xFF, 0x01 with valid held high.
  - cfg_sdo bit sequence is 10100101 00111100 11111111 00000001.
  - cfg_shift is high in 4 bursts of 8 cycles, each separated by 1 word_ready cycle.
  - One cfg_latch pulse, done on the next cycle, 38 cycles total.
- **Stalled producer:** hold word_valid low for 5 cycles before word 3 → word_ready stays 1 and cfg_shift stays 0 for those cycles. The final bit stream is identical to the full-load test and the session is 43 cycles.
- **Abort:** abort during bit 4 of word 3 → IDLE on the next cycle, busy=0, no cfg_latch and no done. A fresh start then completes normally.
- **Ignored inputs:**
  - start pulsed during SHIFT: no effect.
  - word_valid=1 in IDLE: word_ready stays 0.
  - start and abort together in IDLE: busy stays 0.
- **Parameter sweep:** WORD_W=4, CHAIN_LEN=4 (NWORDS=1) with word 0x9 → cfg_sdo is 1,0,0,1, then cfg_latch and done. Session is 7 cycles.

Source files
------------

// File: rtl/act_cfg_loader.sv
// act_cfg_loader: writer end of the logic-module configuration chain.
// Accepts configuration words over valid/ready, shifts them MSB first onto
// the scan chain, then strobes cfg_latch so the cells capture the chain.
module act_cfg_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_sdo,
  output logic              cfg_shift,
  output logic              cfg_latch,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWORDS = CHAIN_LEN / WORD_W;
  localparam int unsigned BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    SHIFT     = 3'd2,
    LATCH     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;

  // Output values for the next cycle; decoded from next state so the
  // registered outputs are exactly the Moore decode of the state register.
  logic word_ready_d, cfg_sdo_d, cfg_shift_d, cfg_latch_d, busy_d, done_d;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      word_ready <= 1'b0;
      cfg_sdo    <= 1'b0;
      cfg_shift  <= 1'b0;
      cfg_latch  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_ready <= word_ready_d;
      cfg_sdo    <= cfg_sdo_d;
      cfg_shift  <= cfg_shift_d;
      cfg_latch  <= cfg_latch_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = WAIT_WORD;
          word_cnt_d = '0;
        end
      end
      WAIT_WORD: begin
        if (word_valid) begin
          sreg_d    = word_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d    = {sreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          if (word_cnt_q == WORD_LAST) begin
            state_d = LATCH;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = WAIT_WORD;
          end
        end
      end
      LATCH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort drops the session; chain contents already shifted stay put.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      sreg_d     = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end

    word_ready_d = (state_d == WAIT_WORD);
    cfg_shift_d  = (state_d == SHIFT);
    cfg_sdo_d    = (state_d == SHIFT) && sreg_d[WORD_W-1];
    cfg_latch_d  = (state_d == LATCH);
    done_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

endmodule
